// File: rtl/uart_periph.sv
// -----------------------------------------------------------------------------
// uart_periph
//
// Memory-mapped 8N1 UART with three word registers starting at BASE:
//   BASE+0  UART_TXD  write: byte to send (accepted only when idle)
//                     read:  last accepted byte
//   BASE+4  UART_RXD  read:  last received byte (reading clears RX_VALID)
//   BASE+8  UART_CON  [0] RX_INT_EN  [1] TX_INT_EN  (read/write)
//                     [2] RX_VALID   [3] TX_DONE    (read-only, TX_DONE sticky)
//                     [4] TX_BUSY    [5] RX_OVERRUN (read-only, RX_OVERRUN sticky)
//                     reading clears TX_DONE and RX_OVERRUN
//
// Ports
//   clk    system clock (single domain)
//   reset  synchronous, active-high reset
//   addr   CPU byte address; only the three exact word addresses decode
//   wdata  CPU write data
//   rd     read strobe; rdata is combinational and zero unless rd hits a register
//   wr     write strobe
//   rdata  read data
//   rx     asynchronous serial input (idles high)
//   tx     serial output (idles high)
//   irq    level interrupt, derived only from register state
// -----------------------------------------------------------------------------
module uart_periph #(
    parameter int          CLKS_PER_BIT = 5208,
    parameter logic [31:0] BASE         = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] rdata,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);

    localparam int SYNC_STAGES = 2;
    localparam int CW          = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic sel_txd, sel_rxd, sel_con;
    logic txd_wr, con_wr, rxd_rd, con_rd;

    assign sel_txd = (addr == BASE);
    assign sel_rxd = (addr == BASE + 32'd4);
    assign sel_con = (addr == BASE + 32'd8);

    assign txd_wr = wr & sel_txd;
    assign con_wr = wr & sel_con;
    assign rxd_rd = rd & sel_rxd;
    assign con_rd = rd & sel_con;

    // Upper write-data bits have no destination.
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:8];

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [7:0] txd_reg;
    logic [7:0] rxd_reg;
    logic       rx_int_en_reg;
    logic       tx_int_en_reg;
    logic       rx_valid_reg;
    logic       tx_done_reg;
    logic       tx_busy_reg;
    logic       rx_overrun_reg;

    logic [31:0] con_value;
    assign con_value = {26'd0, rx_overrun_reg, tx_busy_reg, tx_done_reg,
                        rx_valid_reg, tx_int_en_reg, rx_int_en_reg};

    always_comb begin
        rdata = 32'h0;
        if (rd) begin
            if (sel_txd)      rdata = {24'd0, txd_reg};
            else if (sel_rxd) rdata = {24'd0, rxd_reg};
            else if (sel_con) rdata = con_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_int_en_reg <= 1'b0;
            tx_int_en_reg <= 1'b0;
        end else if (con_wr) begin
            rx_int_en_reg <= wdata[0];
            tx_int_en_reg <= wdata[1];
        end
    end

    assign irq = (rx_int_en_reg & rx_valid_reg) | (tx_int_en_reg & tx_done_reg);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    tx_state_t   tx_state_reg;
    logic [CW-1:0] tx_baud_reg;
    logic [2:0]  tx_bit_reg;
    logic        tx_reg;

    assign tx = tx_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_reg <= TX_IDLE;
            tx_baud_reg  <= '0;
            tx_bit_reg   <= 3'd0;
            tx_reg       <= 1'b1;
            txd_reg      <= 8'd0;
            tx_busy_reg  <= 1'b0;
            tx_done_reg  <= 1'b0;
        end else begin
            // Clear first so a completion in the same cycle is not lost.
            if (con_rd)
                tx_done_reg <= 1'b0;

            case (tx_state_reg)
                TX_IDLE: begin
                    if (txd_wr) begin
                        txd_reg      <= wdata[7:0];
                        tx_busy_reg  <= 1'b1;
                        tx_reg       <= 1'b0;
                        tx_baud_reg  <= '0;
                        tx_state_reg <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_baud_reg == BAUD_LAST) begin
                        tx_baud_reg  <= '0;
                        tx_bit_reg   <= 3'd0;
                        tx_reg       <= txd_reg[0];
                        tx_state_reg <= TX_DATA;
                    end else begin
                        tx_baud_reg <= tx_baud_reg + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_baud_reg == BAUD_LAST) begin
                        tx_baud_reg <= '0;
                        if (tx_bit_reg == 3'd7) begin
                            tx_reg       <= 1'b1;
                            tx_state_reg <= TX_STOP;
                        end else begin
                            tx_bit_reg <= tx_bit_reg + 3'd1;
                            tx_reg     <= txd_reg[tx_bit_reg + 3'd1];
                        end
                    end else begin
                        tx_baud_reg <= tx_baud_reg + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_baud_reg == BAUD_LAST) begin
                        tx_baud_reg  <= '0;
                        tx_busy_reg  <= 1'b0;
                        tx_done_reg  <= 1'b1;
                        tx_state_reg <= TX_IDLE;
                    end else begin
                        tx_baud_reg <= tx_baud_reg + 1'b1;
                    end
                end
                default: begin
                    tx_state_reg <= TX_IDLE;
                    tx_reg       <= 1'b1;
                    tx_busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive synchronizer
    //
    // Each stage carries a "live" flag alongside the data flop. The flag
    // marks that the stage now holds a genuine sample of rx rather than
    // its reset value, so a line that is already low when reset drops is
    // not mistaken for a start bit.
    // ------------------------------------------------------------------
    logic sync_reg [SYNC_STAGES];
    logic live_reg [SYNC_STAGES];

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_reg[gi] <= 1'b1;
                    live_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    sync_reg[gi] <= rx;
                    live_reg[gi] <= 1'b1;
                end else begin
                    sync_reg[gi] <= sync_reg[gi-1];
                    live_reg[gi] <= live_reg[gi-1];
                end
            end
        end
    endgenerate

    logic rx_s;
    logic rx_live;
    logic rx_prev_reg;
    logic rx_fall;

    assign rx_s    = sync_reg[SYNC_STAGES-1];
    assign rx_live = live_reg[SYNC_STAGES-1];

    // rx_prev_reg only becomes 1 once a genuine high has been observed.
    always_ff @(posedge clk) begin
        if (reset) rx_prev_reg <= 1'b0;
        else       rx_prev_reg <= rx_live & rx_s;
    end

    assign rx_fall = rx_prev_reg & ~rx_s;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK        // framing error: wait for the line to return high
    } rx_state_t;

    rx_state_t     rx_state_reg;
    logic [CW-1:0] rx_baud_reg;
    logic [2:0]    rx_bit_reg;
    logic [7:0]    rx_shift_reg;
    logic          rx_byte_ok;

    assign rx_byte_ok = (rx_state_reg == RX_STOP) && (rx_baud_reg == BAUD_LAST) && rx_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_reg   <= RX_IDLE;
            rx_baud_reg    <= '0;
            rx_bit_reg     <= 3'd0;
            rx_shift_reg   <= 8'd0;
            rxd_reg        <= 8'd0;
            rx_valid_reg   <= 1'b0;
            rx_overrun_reg <= 1'b0;
        end else begin
            if (con_rd)
                rx_overrun_reg <= 1'b0;

            // A byte completing in the same cycle as an RXD read wins:
            // the read returns the old byte and the new one stays valid.
            if (rx_byte_ok) begin
                rxd_reg      <= rx_shift_reg;
                rx_valid_reg <= 1'b1;
                if (rx_valid_reg && !rxd_rd)
                    rx_overrun_reg <= 1'b1;
            end else if (rxd_rd) begin
                rx_valid_reg <= 1'b0;
            end

            case (rx_state_reg)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_baud_reg  <= '0;
                        rx_state_reg <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_baud_reg == BAUD_HALF) begin
                        rx_baud_reg <= '0;
                        rx_bit_reg  <= 3'd0;
                        if (rx_s) rx_state_reg <= RX_IDLE;    // glitch
                        else      rx_state_reg <= RX_DATA;
                    end else begin
                        rx_baud_reg <= rx_baud_reg + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_baud_reg == BAUD_LAST) begin
                        rx_baud_reg  <= '0;
                        rx_shift_reg <= {rx_s, rx_shift_reg[7:1]};   // LSB first
                        if (rx_bit_reg == 3'd7) rx_state_reg <= RX_STOP;
                        else                    rx_bit_reg   <= rx_bit_reg + 3'd1;
                    end else begin
                        rx_baud_reg <= rx_baud_reg + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_baud_reg == BAUD_LAST) begin
                        rx_baud_reg <= '0;
                        if (rx_s) rx_state_reg <= RX_IDLE;
                        else      rx_state_reg <= RX_BREAK;
                    end else begin
                        rx_baud_reg <= rx_baud_reg + 1'b1;
                    end
                end
                RX_BREAK: begin
                    if (rx_s) rx_state_reg <= RX_IDLE;
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_periph.sv
// -----------------------------------------------------------------------------
// tb_uart_periph
//
// Directed testbench for uart_periph with CLKS_PER_BIT=16. Inputs are driven
// on the falling clock edge; outputs are sampled 1 ns after driving or on
// the falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_uart_periph;

    localparam int          CPB  = 16;
    localparam logic [31:0] BASE = 32'h4000_0018;
    localparam logic [31:0] TXD  = BASE;
    localparam logic [31:0] RXD  = BASE + 32'd4;
    localparam logic [31:0] CON  = BASE + 32'd8;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic [31:0] rdata;
    logic        rx;
    logic        tx;
    logic        irq;

    int checks_total;
    int checks_passed;

    uart_periph #(
        .CLKS_PER_BIT (CPB),
        .BASE         (BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .wdata (wdata),
        .rd    (rd),
        .wr    (wr),
        .rdata (rdata),
        .rx    (rx),
        .tx    (tx),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp)
            checks_passed++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a;
        rd   = 1'b1;
        #1;
        d = rdata;
        @(posedge clk);
        #1;
        rd = 1'b0;
        $display("read  addr=0x%08h data=0x%08h", a, d);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        @(posedge clk);
        #1;
        wr = 1'b0;
        $display("write addr=0x%08h data=0x%08h", a, d);
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    // Follows a frame that was accepted at the previous rising edge: checks
    // tx on every cycle, TX_BUSY once per bit, and optionally attempts a
    // second TXD write at cycle 40 that must be dropped.
    task automatic tx_frame_check(input logic [7:0] b, input bit intrude, input logic [7:0] ib);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int c = 0; c < 10 * CPB; c++) begin
            @(negedge clk);
            rd = 1'b0;
            wr = 1'b0;
            check($sformatf("tx_bit%0d_cyc%0d", c / CPB, c), 32'(tx), 32'(frame[c / CPB]));
            if (c % CPB == 4) begin
                addr = CON;
                rd   = 1'b1;
                #1;
                check("tx_busy", 32'(rdata[4]), 32'd1);
            end
            if (intrude && c == 40) begin
                addr  = TXD;
                wdata = {24'd0, ib};
                wr    = 1'b1;
            end
        end
        @(negedge clk);
        rd = 1'b0;
        wr = 1'b0;
        $display("tx frame 0x%02h observed", b);
    endtask

    task automatic rx_send(input logic [7:0] b, input bit stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        @(posedge clk);
        #2;
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            repeat (CPB) @(posedge clk);
            #2;
        end
        rx = 1'b1;
        $display("rx frame 0x%02h sent, stop=%0d", b, stop);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        reset = 1'b1;
        rx    = 1'b1;
        rd    = 1'b0;
        wr    = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_irq", 32'(irq), 32'd0);
        read_check("reset_txd", TXD, 32'h0);
        read_check("reset_rxd", RXD, 32'h0);
        read_check("reset_con", CON, 32'h0);
        read_check("unmapped_read", BASE + 32'd12, 32'h0);

        // TX 0x55 with TX interrupt enabled
        bus_write(CON, 32'h2);
        bus_write(TXD, 32'h55);
        tx_frame_check(8'h55, 1'b0, 8'h00);
        check("tx55_irq", 32'(irq), 32'd1);
        read_check("tx55_con", CON, 32'h0000_000A);
        @(negedge clk);
        check("tx55_irq_cleared", 32'(irq), 32'd0);
        read_check("tx55_txd", TXD, 32'h55);
        @(negedge clk);
        addr = TXD;
        #1;
        check("rd_low_rdata", rdata, 32'h0);

        // TX 0x0F, with a 0xF0 write during the frame that must be dropped
        bus_write(TXD, 32'h0F);
        tx_frame_check(8'h0F, 1'b1, 8'hF0);
        read_check("tx0f_con", CON, 32'h0000_000A);
        read_check("tx0f_txd", TXD, 32'h0F);

        // RX 0xA3 with RX interrupt enabled
        bus_write(CON, 32'h1);
        rx_send(8'hA3, 1'b1);
        check("rxa3_irq", 32'(irq), 32'd1);
        read_check("rxa3_con_valid", CON, 32'h0000_0005);
        read_check("rxa3_rxd", RXD, 32'h0000_00A3);
        read_check("rxa3_con_cleared", CON, 32'h0000_0001);
        check("rxa3_irq_cleared", 32'(irq), 32'd0);

        // Overrun: 0x11 then 0x22 without reading
        rx_send(8'h11, 1'b1);
        rx_send(8'h22, 1'b1);
        read_check("ovr_rxd", RXD, 32'h22);
        read_check("ovr_con_set", CON, 32'h0000_0021);
        read_check("ovr_con_clear", CON, 32'h0000_0001);

        // Framing error: byte discarded, prior byte kept
        rx_send(8'h7E, 1'b0);
        repeat (30) @(posedge clk);
        read_check("frm_con", CON, 32'h0000_0001);
        read_check("frm_rxd", RXD, 32'h22);

        // Short low pulse is a glitch; the receiver still works afterwards
        @(posedge clk);
        #2;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rx = 1'b1;
        repeat (40) @(posedge clk);
        read_check("glitch_con", CON, 32'h0000_0001);
        rx_send(8'hC4, 1'b1);
        read_check("c4_con", CON, 32'h0000_0005);
        read_check("c4_rxd", RXD, 32'hC4);
        read_check("c4_con_cleared", CON, 32'h0000_0001);

        // Reset in the middle of a TX frame and an RX frame
        fork
            rx_send(8'h5A, 1'b1);
        join_none
        bus_write(TXD, 32'h33);
        repeat (50) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_irq", 32'(irq), 32'd0);
        read_check("midrst_txd", TXD, 32'h0);
        read_check("midrst_rxd", RXD, 32'h0);
        read_check("midrst_con", CON, 32'h0);
        wait fork;
        repeat (200) @(posedge clk);

        // Normal operation after the mid-frame reset
        bus_write(TXD, 32'h3C);
        tx_frame_check(8'h3C, 1'b0, 8'h00);
        read_check("post_txd", TXD, 32'h3C);
        rx_send(8'h96, 1'b1);
        read_check("post_rxd", RXD, 32'h96);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/uart_periph.md
UART_PERIPH -- requirements
Module: uart_periph

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, giving clk cycles per UART bit (50 MHz / 9600 baud).
REQ-002 SHALL have parameter BASE, default 32'h4000_0018, giving the address of the first register.
REQ-003 SHALL have port clk, input, 1 bit: system clock; one clock domain only.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port addr, input, 32 bits: CPU byte address; only word-aligned accesses are decoded.
REQ-006 SHALL have port wdata, input, 32 bits: CPU write data.
REQ-007 SHALL have port rd, input, 1 bit: CPU read strobe.
REQ-008 SHALL have port wr, input, 1 bit: CPU write strobe.
REQ-009 SHALL have port rdata, output, 32 bits: read data; combinational from addr.
REQ-010 SHALL have port rx, input, 1 bit: asynchronous serial input; idles high.
REQ-011 SHALL have port tx, output, 1 bit: serial output; idles high.
REQ-012 SHALL have port irq, output, 1 bit: level interrupt request.

Function
REQ-013 SHALL map its registers as follows:
- UART_TXD at BASE+0: write [7:0] = byte to send; read returns the last written byte.
- UART_RXD at BASE+4: read-only; [7:0] = last received byte.
- UART_CON at BASE+8: [0] RX_INT_EN (RW), [1] TX_INT_EN (RW), [2] RX_VALID (RO), [3] TX_DONE (RO, sticky), [4] TX_BUSY (RO), [5] RX_OVERRUN (RO, sticky).
REQ-014 SHALL return zero-extended values on rdata for decoded addresses with rd=1, and 32'h0 otherwise; unused bits read 0.
REQ-015 SHALL ignore writes to addresses outside the three registers, and to read-only fields.
REQ-016 SHALL clear RX_VALID on the clk edge of a read of UART_RXD (rd=1).
REQ-017 SHALL clear TX_DONE and RX_OVERRUN on the clk edge of a read of UART_CON; rdata in that cycle shows the pre-clear values.
REQ-018 SHALL drive irq = (RX_INT_EN & RX_VALID) | (TX_INT_EN & TX_DONE), registered-state only (no combinational path from the bus).
REQ-019 SHALL run the TX FSM IDLE -> START -> DATA -> STOP -> IDLE, with each state holding exactly CLKS_PER_BIT cycles.
- Frame: 8N1, LSB first.
- A write to UART_TXD while in IDLE latches the byte, sets TX_BUSY, and drives tx=0 starting the next cycle.
REQ-020 SHALL, at the end of STOP, clear TX_BUSY, set TX_DONE, and return to IDLE in the same cycle.
REQ-021 SHALL drop a UART_TXD write made while TX_BUSY=1: the frame in progress, the stored byte and the read-back are all unchanged.
REQ-022 SHALL pass rx through a 2-flop synchronizer before any use; all RX timing below is measured on the synchronized signal.
REQ-023 SHALL run the RX FSM IDLE -> START -> DATA -> STOP -> IDLE:
- IDLE -> START on a synchronized falling edge.
- START samples at CLKS_PER_BIT/2; a high level is a glitch and returns to IDLE.
- DATA samples each of the 8 bits CLKS_PER_BIT after the previous sample.
- STOP samples one bit later.
REQ-024 SHALL, on a stop sample of 1, load UART_RXD and set RX_VALID in the same cycle.
REQ-025 SHALL, on a stop sample of 0 (framing error), discard the byte: UART_RXD and RX_VALID are unchanged, and the FSM returns to IDLE only after rx reads high.
REQ-026 SHALL, when a byte completes while RX_VALID=1 and no RXD read occurs that cycle, overwrite UART_RXD and set RX_OVERRUN.
REQ-027 SHALL, when an RXD read coincides with a byte completing, let the new byte win: RX_VALID=1 with the new data and RX_OVERRUN unchanged; the read returns the old byte.
REQ-028 SHALL operate TX and RX fully independently, so full-duplex traffic is supported.
REQ-029 SHALL accept a UART_CON write coinciding with TX_DONE or RX_VALID being set without losing either event.

Reset
REQ-030 SHALL, while reset=1 at a clk edge, set the following regardless of bus or rx activity, aborting any frame in progress:
- tx=1, irq=0.
- Both FSMs in IDLE, with their bit and baud counters at 0.
- UART_TXD=0, UART_RXD=0, UART_CON=0.
- Synchronizer flops = 1.
REQ-031 SHALL, after reset deasserts, ignore an rx line that is already low until it has been seen high at least once.

Verification (CLKS_PER_BIT=16)
REQ-032 Bench SHALL cover: write 0x55 to UART_TXD -> tx low for 16 cycles, then 1,0,1,0,1,0,1,0 at 16 cycles each, then high for 16; TX_BUSY=1 throughout; then TX_DONE=1, and irq=1 if TX_INT_EN=1.
REQ-033 Bench SHALL cover: drive an rx frame of 0xA3 -> RX_VALID=1 and UART_RXD reads 32'h000000A3; that read clears RX_VALID on the next cycle.
REQ-034 Bench SHALL cover: two rx frames 0x11 then 0x22 with no read -> UART_RXD=0x22 and RX_OVERRUN=1; a UART_CON read returns bit5=1, then reads 0.
REQ-035 Bench SHALL cover: rx frame 0x7E with stop bit 0 -> RX_VALID stays 0 and UART_RXD keeps its prior value; an rx low pulse of 4 cycles -> no byte received.
REQ-036 Bench SHALL cover: write 0x0F, then write 0xF0 at cycle 40 -> the serial frame carries 0x0F only and UART_TXD reads 0x0F.
REQ-037 Bench SHALL cover: assert reset for 1 cycle in the middle of a TX frame and an RX frame -> tx=1 the next cycle, all registers 0, irq=0, and a subsequent frame works normally.
